// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start qualification, mid-bit sampling,
// Rx shift register control, stop check and host handshake.
module uart_rx_ctrl #(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_tick,
  input  logic             rx_in,
  output logic             rsr_d_in,
  output logic             rsr_en,
  output logic             rsr_ld_sh,
  input  logic [WIDTH-1:0] rsr_q,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t state, state_n;

  logic rx_m, rx_s;

  logic [TW-1:0] tick_cnt, tick_n, tick_inc;
  logic [BW-1:0] bit_cnt, bit_n;

  logic             d_in_n;
  logic             en_n;
  logic             ld_n;
  logic [WIDTH-1:0] data_n;
  logic             valid_n;
  logic             fe_n;
  logic             ov_n;

  assign tick_inc = tick_cnt + TW'(1);

  // two-flop synchronizer for the asynchronous line, idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  // state and tick/bit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
    end
  end

  // next state, counters and next registered outputs
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    d_in_n  = rsr_d_in;
    en_n    = 1'b0;
    ld_n    = 1'b0;
    data_n  = rx_data;
    valid_n = rx_valid & ~rx_ready;
    fe_n    = 1'b0;
    ov_n    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (baud_tick && !rx_s) begin
          tick_n  = '0;
          state_n = S_START;
        end
      end

      S_START: begin
        if (baud_tick) begin
          tick_n = tick_inc;
          if (tick_inc == T_MID) begin
            if (!rx_s) begin
              en_n    = 1'b1;
              ld_n    = 1'b1;
              tick_n  = '0;
              bit_n   = '0;
              state_n = S_DATA;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          tick_n = tick_inc;
          if (tick_inc == T_LAST) begin
            en_n   = 1'b1;
            d_in_n = rx_s;
            if (bit_cnt == B_LAST) begin
              bit_n   = '0;
              state_n = S_STOP;
            end else begin
              bit_n = bit_cnt + BW'(1);
            end
          end
        end
      end

      S_STOP: begin
        if (baud_tick) begin
          tick_n = tick_inc;
          if (tick_inc == T_LAST) begin
            if (rx_s) begin
              data_n  = rsr_q;
              valid_n = 1'b1;
              ov_n    = rx_valid & ~rx_ready;
            end else begin
              fe_n = 1'b1;
            end
            state_n = S_IDLE;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rsr_d_in  <= 1'b0;
      rsr_en    <= 1'b0;
      rsr_ld_sh <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsr_d_in  <= d_in_n;
      rsr_en    <= en_n;
      rsr_ld_sh <= ld_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= fe_n;
      overrun   <= ov_n;
      busy      <= (state_n != S_IDLE);
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side sequencer for the UART. It watches the serial line, qualifies the start bit, and samples each data bit at mid-bit on a 16x oversampling tick. It drives the Rx shift register (SIPO) through its enable/load-shift controls and checks the stop bit. Each completed word is presented to the host side with a valid/ready handshake, plus framing-error and overrun flags.

## Interface
- WIDTH, 8: data bits per frame; must match the Rx shift register width.
- OVERSAMPLE, 16: baud_tick pulses per bit period; even, 8..32.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- baud_tick  in  1  one-clk pulse, OVERSAMPLE per bit period.
- rx_in  in  1  raw serial line, asynchronous, idle high.
- rsr_d_in  out  1  sampled bit, to shift register d_in.
- rsr_en  out  1  shift register enable.
- rsr_ld_sh  out  1  shift register mode:
  - rsr_en=1 with rsr_ld_sh=1 clears the register.
  - rsr_en=1 with rsr_ld_sh=0 shifts rsr_d_in in.
- rsr_q  in  WIDTH  shift register d_out.
- rx_data  out  WIDTH  received word, LSB first on the line.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data when rx_valid=1.
- frame_err  out  1  one-clk pulse: stop bit sampled low.
- overrun  out  1  one-clk pulse: word completed while previous word still unconsumed.
- busy  out  1  high in any state other than IDLE.

## Operation
- **Input synchronizer.** rx_in passes through a 2-flop synchronizer (rx_s); both flops reset to 1. All decisions use rx_s.
- **Counters.**
  - tick_cnt: log2(OVERSAMPLE) bits, counts baud_tick pulses only.
  - bit_cnt: 0..WIDTH-1.
- **IDLE.** On a baud_tick with rx_s=0: clear tick_cnt, go to START.
- **START.** On each tick, tick_cnt++. When the tick brings tick_cnt to OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0: issue the clear command (rsr_en=1, rsr_ld_sh=1), clear tick_cnt and bit_cnt, go to DATA.
  - rx_s=1: glitch; go to IDLE with no other output.
- **DATA.** On each tick, tick_cnt++ (wraps). When the tick brings tick_cnt to OVERSAMPLE-1 (mid-bit):
  - Issue a shift: rsr_en=1, rsr_ld_sh=0, rsr_d_in=rx_s.
  - bit_cnt++. After shift number WIDTH, go to STOP.
- **STOP.** At the next mid-bit tick (tick_cnt reaches OVERSAMPLE-1):
  - rx_s=1: rx_data <= rsr_q.
    - rx_valid=0 beforehand: set rx_valid=1.
    - rx_valid=1 and not consumed this cycle: overwrite rx_data, keep rx_valid=1, pulse overrun.
  - rx_s=0: pulse frame_err. rx_data and rx_valid are unchanged.
  - Either way, go to IDLE immediately (mid stop bit), so a following start edge can be caught.
- **Handshake.**
  - rx_valid=1 and rx_ready=1 in the same cycle: the word is consumed and rx_valid clears at the next edge.
  - Consumption and a new capture in the same cycle: load the new word, rx_valid stays 1, no overrun.
- **Idle outputs.** rsr_en=0 and rsr_ld_sh=0 whenever no command is issued. rsr_d_in holds its last value.
- **baud_tick outside IDLE/START/DATA/STOP sampling points:** only counts ticks; no other effect.
- **Reset.** rst in any state, including mid-frame, returns to IDLE at the next edge. No partial-word output, no frame_err.

## Timing
- **Reset values:**
  - rsr_d_in=0, rsr_en=0, rsr_ld_sh=0.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops=1; state=IDLE; tick_cnt=0, bit_cnt=0.
- **Registered outputs.** All outputs are registered. Each rsr command is asserted for exactly one clk, in the cycle after the qualifying baud_tick cycle.
- **Synchronizer latency.** rx_in to rx_s is 2 clk.
- **Command count per good frame.** Exactly 1 clear followed by exactly WIDTH shifts.
- **Capture.** rx_data, rx_valid, frame_err and overrun all update in the cycle after the stop mid-bit tick. rsr_q has been stable for at least OVERSAMPLE ticks by then.
- **Frame time.** Start edge to rx_valid: 1.5 + WIDTH bit periods of ticks, plus 3 clk (synchronizer + register).

## Test plan
- **Clean frame.** baud_tick every clk, OVERSAMPLE=16, frame 0xA5 LSB-first, stop=1 -> exactly one clear and 8 shifts carrying bits 1,0,1,0,0,1,0,1; rx_data=0xA5, rx_valid=1; frame_err=0, overrun=0.
- **Glitch rejection.** rx_in low for 4 ticks, then high -> returns to IDLE; no rsr_en activity; busy falls after the mid-start sample.
- **Framing error.** Frame 0x3C with stop=0 -> single-cycle frame_err; rx_valid stays 0; busy=0 the next cycle.
- **Overrun.** Two frames, 0x11 then 0x22, with rx_ready=0 -> one overrun pulse; rx_data=0x22, rx_valid=1. Then rx_ready=1 for one clk -> rx_valid=0.
- **Back-to-back.** Frames 0x55 then 0xAA with a single stop bit, rx_ready held at 1 -> both words delivered in order, each rx_valid high for one clk, no overrun.
- **Reset mid-frame.** rst asserted during data bit 4 of 0xFF, then frame 0x81 -> outputs at reset values immediately after rst; next frame delivers 0x81 correctly.
